// File: rtl/cellram_responder_if.sv
// Cellular-RAM async pin bundle between the RAM controller (master) and the
// on-chip responder (slave). MemDB is carried as separate in/out/oe signals;
// the tristate is built at the top level.
//   RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB : controller strobes
//   MemAdr     : 23-bit word address
//   mem_db_in  : write data from controller
//   mem_db_out : read data from responder
//   mem_db_oe  : responder drives MemDB when 1
interface cellram_responder_if;
  logic        RamAdv;
  logic        RamClk;
  logic        RamCS;
  logic        MemOE;
  logic        MemWR;
  logic        RamLB;
  logic        RamUB;
  logic [22:0] MemAdr;
  logic [15:0] mem_db_in;
  logic [15:0] mem_db_out;
  logic        mem_db_oe;

  modport master (
    output RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB, MemAdr, mem_db_in,
    input  mem_db_out, mem_db_oe
  );

  modport slave (
    input  RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB, MemAdr, mem_db_in,
    output mem_db_out, mem_db_oe
  );
endinterface

// File: rtl/cellram_responder.sv
// Cellular-RAM responder: emulates an async PSRAM on the controller pins using
// on-chip storage (2**ADDR_W x 16) with a modelled access time of ACCESS_CYCLES clk.
//   clk       : system clock
//   rst       : asynchronous reset, active-low
//   bus       : Cellular-RAM pin bundle (slave side)
//   rd_count  : completed reads, wrapping
//   wr_count  : committed writes, wrapping
//   proto_err : sticky protocol-violation flag, cleared only by reset
module cellram_responder #(
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned ACCESS_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  cellram_responder_if.slave bus,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count,
  output logic               proto_err
);

  localparam int unsigned       TimerW      = $clog2(ACCESS_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerOne    = TimerW'(1);
  localparam logic [TimerW-1:0] TimerLast   = TimerW'(ACCESS_CYCLES - 1);
  localparam bit                SingleCycle = (ACCESS_CYCLES == 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StRdDrive,
    StWrWait,
    StWrArmed
  } state_e;

  // Pin input register stage
  logic        cs_q, wr_q, oe_n_q, lb_q, ub_q, ramclk_q;
  logic [22:0] adr_q;
  logic [15:0] din_q;

  // Address valid has no meaning in async mode
  logic unused_adv;
  assign unused_adv = bus.RamAdv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_q     <= 1'b1;
      wr_q     <= 1'b1;
      oe_n_q   <= 1'b1;
      lb_q     <= 1'b1;
      ub_q     <= 1'b1;
      ramclk_q <= 1'b0;
      adr_q    <= '0;
      din_q    <= '0;
    end else begin
      cs_q     <= bus.RamCS;
      wr_q     <= bus.MemWR;
      oe_n_q   <= bus.MemOE;
      lb_q     <= bus.RamLB;
      ub_q     <= bus.RamUB;
      ramclk_q <= bus.RamClk;
      adr_q    <= bus.MemAdr;
      din_q    <= bus.mem_db_in;
    end
  end

  // Access decode on sampled pins; WR wins over OE
  logic is_write, is_read, in_range;
  assign is_write = !cs_q && !wr_q;
  assign is_read  = !cs_q && wr_q && !oe_n_q;
  assign in_range = (adr_q >> ADDR_W) == 23'd0;

  // Storage (contents survive reset)
  logic [15:0]       mem [2**ADDR_W];
  logic [15:0]       mem_word;
  logic [15:0]       rd_word;

  assign mem_word = mem[adr_q[ADDR_W-1:0]];

  always_comb begin
    rd_word = in_range ? mem_word : 16'h0000;
    if (lb_q) rd_word[7:0]  = 8'h00;
    if (ub_q) rd_word[15:8] = 8'h00;
  end

  // Write latch: follows the bus on every sampled WRITE cycle so that the
  // commit uses the values seen just before the write strobe rose.
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] wadr_q;
  logic              wlb_q, wub_q, wok_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdata_q <= '0;
      wadr_q  <= '0;
      wlb_q   <= 1'b1;
      wub_q   <= 1'b1;
      wok_q   <= 1'b0;
    end else if (is_write) begin
      wdata_q <= din_q;
      wadr_q  <= adr_q[ADDR_W-1:0];
      wlb_q   <= lb_q;
      wub_q   <= ub_q;
      wok_q   <= in_range;
    end
  end

  state_e            state_q;
  logic [TimerW-1:0] timer_q;
  logic [22:0]       rd_adr_q;
  logic              drive_q;
  logic [15:0]       dout_q;
  logic              commit;

  // Commit happens on the edge that sees WRITE released from the armed state
  assign commit = (state_q == StWrArmed) && !is_write && wok_q;

  always_ff @(posedge clk) begin
    if (commit) begin
      if (!wlb_q) mem[wadr_q][7:0]  <= wdata_q[7:0];
      if (!wub_q) mem[wadr_q][15:8] <= wdata_q[15:8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      rd_adr_q  <= '0;
      drive_q   <= 1'b0;
      dout_q    <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (!cs_q && ramclk_q) proto_err <= 1'b1;
      if ((is_read || is_write) && !in_range) proto_err <= 1'b1;

      unique case (state_q)
        StIdle: begin
          timer_q <= TimerOne;
          if (is_write) begin
            state_q <= SingleCycle ? StWrArmed : StWrWait;
          end else if (is_read) begin
            rd_adr_q <= adr_q;
            if (SingleCycle) begin
              state_q <= StRdDrive;
              drive_q <= 1'b1;
              dout_q  <= rd_word;
            end else begin
              state_q <= StRdWait;
            end
          end
        end

        StRdWait: begin
          if (is_write) begin
            state_q <= StWrWait;
            timer_q <= TimerOne;
          end else if (!is_read) begin
            state_q <= StIdle;
          end else if (adr_q != rd_adr_q) begin
            timer_q  <= TimerOne;
            rd_adr_q <= adr_q;
          end else if (timer_q >= TimerLast) begin
            state_q <= StRdDrive;
            drive_q <= 1'b1;
            dout_q  <= rd_word;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        StRdDrive: begin
          if (is_write) begin
            // Direct switch to write aborts the read uncounted
            drive_q <= 1'b0;
            state_q <= StWrWait;
            timer_q <= TimerOne;
          end else if (!is_read) begin
            drive_q  <= 1'b0;
            rd_count <= rd_count + 16'd1;
            state_q  <= StIdle;
          end else if (adr_q != rd_adr_q) begin
            drive_q  <= 1'b0;
            state_q  <= StRdWait;
            timer_q  <= TimerOne;
            rd_adr_q <= adr_q;
          end else begin
            dout_q <= rd_word;
          end
        end

        StWrWait: begin
          if (is_write) begin
            if (timer_q >= TimerLast) state_q <= StWrArmed;
            else                      timer_q <= timer_q + 1'b1;
          end else begin
            // Write released before the access time elapsed: dropped
            proto_err <= 1'b1;
            if (is_read) begin
              state_q  <= StRdWait;
              timer_q  <= TimerOne;
              rd_adr_q <= adr_q;
            end else begin
              state_q <= StIdle;
            end
          end
        end

        StWrArmed: begin
          if (!is_write) begin
            if (wok_q) wr_count <= wr_count + 16'd1;
            if (is_read) begin
              state_q  <= StRdWait;
              timer_q  <= TimerOne;
              rd_adr_q <= adr_q;
            end else begin
              state_q <= StIdle;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  // Gate with sampled WR so the bus is released the cycle WR is seen low
  assign bus.mem_db_oe  = drive_q && wr_q;
  assign bus.mem_db_out = dout_q;

endmodule

// File: tb/tb_cellram_responder.sv
module tb_cellram_responder;

  localparam int unsigned AW  = 10;
  localparam int unsigned ACC = 4;

  logic        clk;
  logic        rst;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic        proto_err;

  cellram_responder_if bus ();

  cellram_responder #(
    .ADDR_W       (AW),
    .ACCESS_CYCLES(ACC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rd_count (rd_count),
    .wr_count (wr_count),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_rd  = 0;
  int          exp_wr  = 0;
  logic [15:0] model [1024];
  logic [15:0] sb_q [$];

  // Scoreboard monitor: each rising mem_db_oe pops one expected read word
  logic        oe_prev = 1'b0;
  logic [15:0] sb_exp;
  always @(negedge clk) begin
    if (rst && bus.mem_db_oe && !oe_prev) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_read: got %h, no read expected", bus.mem_db_out);
      end else begin
        sb_exp = sb_q.pop_front();
        if (bus.mem_db_out !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_read_data: got %h, expected %h", bus.mem_db_out, sb_exp);
        end
      end
    end
    oe_prev = bus.mem_db_oe;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_pins();
    bus.RamAdv    = 1'b0;
    bus.RamClk    = 1'b0;
    bus.RamCS     = 1'b1;
    bus.MemOE     = 1'b1;
    bus.MemWR     = 1'b1;
    bus.RamLB     = 1'b0;
    bus.RamUB     = 1'b0;
  endtask

  function automatic logic [15:0] expect_word(input logic [22:0] a, input logic lb,
                                              input logic ub);
    logic [15:0] e;
    if ((a >> AW) != 23'd0) e = 16'h0000;
    else                    e = model[a[AW-1:0]];
    if (lb) e[7:0]  = 8'h00;
    if (ub) e[15:8] = 8'h00;
    return e;
  endfunction

  // Write strobe held for 'hold' cycles; model commits only if held long enough and in range
  task automatic do_write(input logic [22:0] a, input logic [15:0] d, input logic lb,
                          input logic ub, input int hold);
    @(negedge clk);
    bus.MemAdr    = a;
    bus.mem_db_in = d;
    bus.RamLB     = lb;
    bus.RamUB     = ub;
    bus.MemOE     = 1'b1;
    bus.MemWR     = 1'b0;
    bus.RamCS     = 1'b0;
    repeat (hold) @(negedge clk);
    idle_pins();
    repeat (3) @(negedge clk);
    if (hold >= ACC && (a >> AW) == 23'd0) begin
      if (!lb) model[a[AW-1:0]][7:0]  = d[7:0];
      if (!ub) model[a[AW-1:0]][15:8] = d[15:8];
      exp_wr++;
    end
  endtask

  // Read strobe held for 'hold' cycles; lat = cycles until mem_db_oe seen (-1 if never)
  task automatic do_read(input logic [22:0] a, input logic lb, input logic ub, input int hold,
                         output int lat);
    lat = -1;
    sb_q.push_back(expect_word(a, lb, ub));
    @(negedge clk);
    bus.MemAdr = a;
    bus.RamLB  = lb;
    bus.RamUB  = ub;
    bus.MemWR  = 1'b1;
    bus.MemOE  = 1'b0;
    bus.RamCS  = 1'b0;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (lat < 0 && bus.mem_db_oe) lat = i;
    end
    idle_pins();
    repeat (3) @(negedge clk);
    exp_rd++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_pins();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_rd = 0;
    exp_wr = 0;
  endtask

  task automatic test_reset();
    idle_pins();
    bus.MemAdr    = '0;
    bus.mem_db_in = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.mem_db_oe !== 1'b0) begin
      n_fail++; $display("FAIL reset_oe: got %b, expected 0", bus.mem_db_oe);
    end
    n_tests++;
    if (bus.mem_db_out !== 16'h0000) begin
      n_fail++; $display("FAIL reset_out: got %h, expected 0000", bus.mem_db_out);
    end
    n_tests++;
    if ({rd_count, wr_count} !== 32'h0) begin
      n_fail++; $display("FAIL reset_counts: got %h/%h, expected 0/0", rd_count, wr_count);
    end
    n_tests++;
    if (proto_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_proto: got %b, expected 0", proto_err);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat;
    do_write(23'h005, 16'hBEEF, 1'b0, 1'b0, 7);
    do_read(23'h005, 1'b0, 1'b0, 7, lat);
    n_tests++;
    if (lat !== 5) begin
      n_fail++; $display("FAIL read_latency: got %0d cycles, expected 5", lat);
    end
    n_tests++;
    if (wr_count !== 16'(exp_wr) || rd_count !== 16'(exp_rd)) begin
      n_fail++;
      $display("FAIL wr_rd_counts: got %0d/%0d, expected %0d/%0d", wr_count, rd_count, exp_wr,
               exp_rd);
    end
    n_tests++;
    if (proto_err !== 1'b0) begin
      n_fail++; $display("FAIL wr_rd_proto: got %b, expected 0", proto_err);
    end
  endtask

  task automatic test_byte_lanes();
    int lat;
    do_write(23'h003, 16'hA5A5, 1'b0, 1'b0, 7);
    do_write(23'h003, 16'h1234, 1'b0, 1'b1, 7);
    do_read(23'h003, 1'b0, 1'b0, 7, lat);
    do_read(23'h003, 1'b1, 1'b0, 7, lat);
    n_tests++;
    if (wr_count !== 16'(exp_wr) || rd_count !== 16'(exp_rd)) begin
      n_fail++;
      $display("FAIL lane_counts: got %0d/%0d, expected %0d/%0d", wr_count, rd_count, exp_wr,
               exp_rd);
    end
  endtask

  task automatic test_addr_change();
    logic seen_early;
    int   lat;
    do_write(23'h010, 16'h1010, 1'b0, 1'b0, 7);
    do_write(23'h011, 16'h2211, 1'b0, 1'b0, 7);
    sb_q.push_back(expect_word(23'h011, 1'b0, 1'b0));
    @(negedge clk);
    bus.MemAdr = 23'h010;
    bus.MemWR  = 1'b1;
    bus.MemOE  = 1'b0;
    bus.RamCS  = 1'b0;
    repeat (2) @(negedge clk);
    bus.MemAdr = 23'h011;
    seen_early = 1'b0;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i <= 4 && bus.mem_db_oe) seen_early = 1'b1;
      if (lat < 0 && bus.mem_db_oe) lat = i;
    end
    idle_pins();
    repeat (3) @(negedge clk);
    exp_rd++;
    n_tests++;
    if (seen_early !== 1'b0 || lat !== 5) begin
      n_fail++;
      $display("FAIL addr_change_latency: oe seen early=%b lat=%0d, expected early=0 lat=5",
               seen_early, lat);
    end
    n_tests++;
    if (rd_count !== 16'(exp_rd)) begin
      n_fail++; $display("FAIL addr_change_count: got %0d, expected %0d", rd_count, exp_rd);
    end
  endtask

  // Read -> write -> read with no idle gap between them
  task automatic test_back_to_back();
    int lat;
    sb_q.push_back(expect_word(23'h003, 1'b0, 1'b0));
    @(negedge clk);
    bus.MemAdr = 23'h003;
    bus.MemWR  = 1'b1;
    bus.MemOE  = 1'b0;
    bus.RamCS  = 1'b0;
    repeat (6) @(negedge clk);
    bus.MemAdr    = 23'h008;
    bus.mem_db_in = 16'h5A5A;
    bus.MemWR     = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.mem_db_oe !== 1'b0) begin
      n_fail++; $display("FAIL b2b_oe_release: got %b, expected 0", bus.mem_db_oe);
    end
    repeat (6) @(negedge clk);
    model[8] = 16'h5A5A;
    exp_wr++;
    sb_q.push_back(expect_word(23'h008, 1'b0, 1'b0));
    bus.MemWR = 1'b1;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (lat < 0 && bus.mem_db_oe) lat = i;
    end
    idle_pins();
    repeat (3) @(negedge clk);
    exp_rd++;
    n_tests++;
    if (wr_count !== 16'(exp_wr) || rd_count !== 16'(exp_rd) || proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_counts: got wr=%0d rd=%0d err=%b, expected wr=%0d rd=%0d err=0",
               wr_count, rd_count, proto_err, exp_wr, exp_rd);
    end
  endtask

  task automatic test_short_write();
    int lat;
    do_write(23'h007, 16'h7777, 1'b0, 1'b0, 7);
    do_write(23'h007, 16'h0000, 1'b0, 1'b0, 2);
    n_tests++;
    if (wr_count !== 16'(exp_wr)) begin
      n_fail++; $display("FAIL short_wr_count: got %0d, expected %0d", wr_count, exp_wr);
    end
    n_tests++;
    if (proto_err !== 1'b1) begin
      n_fail++; $display("FAIL short_wr_proto: got %b, expected 1", proto_err);
    end
    do_read(23'h007, 1'b0, 1'b0, 7, lat);
  endtask

  task automatic test_reset_mid_write();
    int lat;
    @(negedge clk);
    bus.MemAdr    = 23'h005;
    bus.mem_db_in = 16'hDEAD;
    bus.RamLB     = 1'b0;
    bus.RamUB     = 1'b0;
    bus.MemWR     = 1'b0;
    bus.RamCS     = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.mem_db_oe, bus.mem_db_out, rd_count, wr_count, proto_err} !== 50'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: oe=%b out=%h rd=%0d wr=%0d err=%b, expected all 0",
               bus.mem_db_oe, bus.mem_db_out, rd_count, wr_count, proto_err);
    end
    idle_pins();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_rd = 0;
    exp_wr = 0;
    do_read(23'h005, 1'b0, 1'b0, 7, lat);
    n_tests++;
    if (wr_count !== 16'd0 || rd_count !== 16'd1) begin
      n_fail++;
      $display("FAIL rst_mid_counts: got wr=%0d rd=%0d, expected wr=0 rd=1", wr_count, rd_count);
    end
  endtask

  task automatic test_out_of_range();
    int lat;
    do_write(23'h000, 16'h0F0F, 1'b0, 1'b0, 7);
    n_tests++;
    if (proto_err !== 1'b0) begin
      n_fail++; $display("FAIL oor_proto_before: got %b, expected 0", proto_err);
    end
    do_write(23'h400, 16'h1111, 1'b0, 1'b0, 7);
    n_tests++;
    if (wr_count !== 16'(exp_wr) || proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_write: got wr=%0d err=%b, expected wr=%0d err=1", wr_count, proto_err,
               exp_wr);
    end
    do_read(23'h400, 1'b0, 1'b0, 7, lat);
    do_read(23'h000, 1'b0, 1'b0, 7, lat);
    n_tests++;
    if (rd_count !== 16'(exp_rd)) begin
      n_fail++; $display("FAIL oor_rd_count: got %0d, expected %0d", rd_count, exp_rd);
    end
  endtask

  task automatic test_ramclk();
    int lat;
    apply_reset();
    n_tests++;
    if (proto_err !== 1'b0) begin
      n_fail++; $display("FAIL ramclk_proto_before: got %b, expected 0", proto_err);
    end
    @(negedge clk);
    bus.RamClk = 1'b1;
    do_read(23'h005, 1'b0, 1'b0, 7, lat);
    n_tests++;
    if (proto_err !== 1'b1 || rd_count !== 16'(exp_rd)) begin
      n_fail++;
      $display("FAIL ramclk_access: got err=%b rd=%0d, expected err=1 rd=%0d", proto_err,
               rd_count, exp_rd);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_addr_change();
    test_back_to_back();
    test_short_write();
    test_reset_mid_write();
    test_out_of_range();
    test_ramclk();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: %0d reads never driven, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
